// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : request FSM states (IDLE / WAIT / DROP)
//   fetch_entry_t : one queued fetch result {pc, inst}
//   INST_BYTES    : fetch stride in bytes
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory read port plus the
// decode-side valid/ready output.
//   master : fetch unit side (drives mem_rreq/mem_raddr, out_valid/out_pc/out_inst)
//   slave  : memory + decode side (drives mem_rdata/mem_data_valid, out_ready)
interface inst_fetch_unit_if;

    logic        mem_rreq;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_data_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        output mem_rreq,
        output mem_raddr,
        input  mem_rdata,
        input  mem_data_valid,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst
    );

    modport slave (
        input  mem_rreq,
        input  mem_raddr,
        output mem_rdata,
        output mem_data_valid,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst
    );

endinterface

// File: rtl/fetch_queue.sv
// First-word fall-through FIFO of fetch results.
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   push, push_entry   : enqueue one entry
//   pop                : dequeue the head entry (ignored when empty)
//   flush              : empty the queue; wins over a same-cycle push/pop
//   head_entry         : current head (valid while !empty)
//   count, full, empty : occupancy
// QDEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int unsigned QDEPTH = 2,
    localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(QDEPTH);

    fetch_entry_t  mem_q [QDEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_en;
    logic          push_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(QDEPTH));
    assign count   = count_q;
    assign pop_en  = pop & ~empty;
    // At full, a push is only accepted when the head leaves in the same cycle.
    assign push_en = push & (~full | pop_en);

    assign head_entry = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_en && !flush && !reset) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, results
// buffered in a small FWFT queue towards decode.
//   clk, reset                  : rising-edge clock, synchronous active-high reset
//   redirect_valid, redirect_pc : one-cycle branch/exception redirect
//   bus (master)                : memory read port and decode valid/ready output
// Parameters: RESET_PC (first fetch address), QDEPTH (queue depth, 2 or 4).
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    inst_fetch_unit_if.master         bus
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          rreq;
    logic          push;
    logic          pop;
    logic          flush;
    logic          outstanding;
    logic          credit_ok;
    logic [31:0]   redirect_target;
    logic [31:0]   word_addr;
    fetch_entry_t  entry_in;
    fetch_entry_t  head;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;

    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign word_addr       = {2'b00, fetch_pc_q[31:2]};
    assign outstanding     = (state_q != IDLE);
    assign credit_ok       = ~q_full && ((32'(q_count) + 32'(outstanding)) < QDEPTH);
    assign entry_in        = '{pc: fetch_pc_q, inst: bus.mem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        rreq       = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                end else if (credit_ok) begin
                    rreq       = 1'b1;
                    req_addr_d = word_addr;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                rreq = 1'b1;
                if (redirect_valid) begin
                    // A response arriving with the redirect is stale; no DROP needed.
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                    state_d    = bus.mem_data_valid ? IDLE : DROP;
                end else if (bus.mem_data_valid) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                end
                if (bus.mem_data_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced to zero while reset is held, independent of flop state.
    assign bus.mem_rreq  = rreq & ~reset;
    assign bus.mem_raddr = reset ? '0 : ((state_q == IDLE) ? word_addr : req_addr_q);
    assign bus.out_valid = ~q_empty & ~reset;
    assign bus.out_pc    = bus.out_valid ? head.pc : '0;
    assign bus.out_inst  = bus.out_valid ? head.inst : '0;
    assign pop           = bus.out_valid & bus.out_ready;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (entry_in),
        .pop        (pop),
        .flush      (flush),
        .head_entry (head),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: cycle table plus directed
// sequences for redirect, reset-abandon and long streaming with wrap.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] waddr);
        return {waddr[19:0], 12'h013};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- memory model ----------------
    int unsigned mem_delay = 1;
    bit          mem_rand  = 1'b0;
    int unsigned rand_hi   = 0;
    bit          m_busy    = 1'b0;
    int unsigned m_cnt     = 0;
    logic [31:0] m_addr    = '0;

    initial begin
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_data_valid = 1'b0;
            bus.mem_rdata      = 32'hDEAD_BEEF;
            if (reset) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    bus.mem_data_valid = 1'b1;
                    bus.mem_rdata      = inst_of(m_addr);
                    m_busy             = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // ---------------- negedge monitor ----------------
    bit          mon_en = 1'b0;
    logic [31:0] exp_pc = '0;
    int unsigned n_pop  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((m_busy || bus.mem_data_valid) && bus.mem_rreq)
                    check32("raddr_hold", bus.mem_raddr, m_addr);
                if (!m_busy && bus.mem_rreq && !bus.mem_data_valid) begin
                    m_busy = 1'b1;
                    m_addr = bus.mem_raddr;
                    m_cnt  = mem_rand ? $urandom_range(rand_hi, 0) : mem_delay;
                end
                if (dut.push)
                    check32("no_push_when_full", 32'(dut.q_full), 32'd0);
                if (mon_en && bus.out_valid && bus.out_ready) begin
                    check32("stream_pc", bus.out_pc, exp_pc);
                    check32("stream_inst", bus.out_inst, inst_of({2'b00, exp_pc[31:2]}));
                    exp_pc = exp_pc + 32'd4;
                    n_pop++;
                end
            end
        end
    end

    // ---------------- cycle table ----------------
    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rreq;
        logic [31:0] e_raddr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic rdy, input logic e_rreq, input logic [31:0] e_raddr,
                                input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_rreq = e_rreq; v.e_raddr = e_raddr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic do_reset();
        tick();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bit ok;
        bit seen_ov;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.out_ready  = 1'b0;

        // memory delay 1: response arrives two cycles after the request cycle
        //               rst redir rpc          rdy  rreq raddr        ov   pc           inst
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       32'h0);
        tbl[3]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       32'h0);
        tbl[4]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       32'h0);
        tbl[5]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h1,       1'b1, 32'h0,       32'h0000_0013);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h1,       1'b1, 32'h0,       32'h0000_0013);
        tbl[7]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h1,       1'b1, 32'h0,       32'h0000_0013);
        tbl[8]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       32'h0000_0013);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       32'h0000_0013);
        tbl[10] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       1'b1, 32'h0,       32'h0000_0013);
        tbl[11] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h2,       1'b1, 32'h4,       32'h0000_1013);
        tbl[12] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h2,       1'b1, 32'h4,       32'h0000_1013);
        tbl[13] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h2,       1'b1, 32'h4,       32'h0000_1013);
        tbl[14] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h3,       1'b1, 32'h8,       32'h0000_2013);
        tbl[15] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h3,       1'b0, 32'h0,       32'h0);
        tbl[16] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h3,       1'b0, 32'h0,       32'h0);
        tbl[17] = mk(1'b0, 1'b1, 32'h103,     1'b0, 1'b0, 32'h0,       1'b1, 32'hC,       32'h0000_3013);
        tbl[18] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h40,      1'b0, 32'h0,       32'h0);
        tbl[19] = mk(1'b0, 1'b1, 32'h200,     1'b0, 1'b1, 32'h40,      1'b0, 32'h0,       32'h0);
        tbl[20] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0);
        tbl[21] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h80,      1'b0, 32'h0,       32'h0);
        tbl[22] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h80,      1'b0, 32'h0,       32'h0);
        tbl[23] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h80,      1'b0, 32'h0,       32'h0);
        tbl[24] = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h81,      1'b1, 32'h200,     32'h0008_0013);

        mem_delay = 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            reset          = tbl[i].rst;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            bus.out_ready  = tbl[i].rdy;
            @(negedge clk);
            check32($sformatf("vec%0d_rreq", i), 32'(bus.mem_rreq), 32'(tbl[i].e_rreq));
            if (tbl[i].e_rreq || tbl[i].rst)
                check32($sformatf("vec%0d_raddr", i), bus.mem_raddr, tbl[i].e_raddr);
            check32($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov || tbl[i].rst) begin
                check32($sformatf("vec%0d_out_pc", i), bus.out_pc, tbl[i].e_pc);
                check32($sformatf("vec%0d_out_inst", i), bus.out_inst, tbl[i].e_inst);
            end
        end
        redirect_valid = 1'b0;

        // Redirect during a long WAIT: DROP, dropped word never surfaces.
        mem_delay     = 20;
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check32("drop_state", 32'(dut.state_q), 32'(DROP));
        check32("drop_rreq", 32'(bus.mem_rreq), 32'd0);
        ok = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen_ov = 1'b1;
            if (bus.mem_data_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check32("drop_resp_seen", 32'(ok), 32'd1);
        tick();
        @(negedge clk);
        check32("drop_next_rreq", 32'(bus.mem_rreq), 32'd1);
        check32("drop_next_raddr", bus.mem_raddr, 32'h40);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check32("drop_out_seen", 32'(ok), 32'd1);
        check32("drop_no_stale", 32'(seen_ov), 32'd0);
        check32("drop_out_pc", bus.out_pc, 32'h100);
        check32("drop_out_inst", bus.out_inst, inst_of(32'h40));

        // Redirect coincident with the response.
        mem_delay     = 3;
        bus.out_ready = 1'b1;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_data_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check32("coinc_resp_seen", 32'(ok), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check32("coinc_out_valid", 32'(bus.out_valid), 32'd0);
        check32("coinc_rreq", 32'(bus.mem_rreq), 32'd1);
        check32("coinc_raddr", bus.mem_raddr, 32'h100);

        // Reset while a request is outstanding and the queue holds an entry.
        bus.out_ready = 1'b0;
        mem_delay     = 0;
        do_reset();
        tick();
        mem_delay = 20;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        @(negedge clk);
        check32("rst_rreq", 32'(bus.mem_rreq), 32'd0);
        check32("rst_raddr", bus.mem_raddr, 32'd0);
        check32("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check32("rst_out_pc", bus.out_pc, 32'd0);
        check32("rst_out_inst", bus.out_inst, 32'd0);
        tick();
        reset         = 1'b0;
        mem_delay     = 2;
        bus.out_ready = 1'b1;
        exp_pc        = 32'h0;
        n_pop         = 0;
        mon_en        = 1'b1;
        @(negedge clk);
        check32("rst_restart_rreq", 32'(bus.mem_rreq), 32'd1);
        check32("rst_restart_raddr", bus.mem_raddr, 32'd0);
        for (int i = 0; i < 100 && n_pop < 4; i++) tick();
        mon_en = 1'b0;
        check32("rst_restart_count", 32'(n_pop >= 4), 32'd1);

        // Long random-delay stream starting just below the 32-bit wrap.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clk);
        check32("wrap_redirect_rreq", 32'(bus.mem_rreq), 32'd0);
        tick();
        redirect_valid = 1'b0;
        mem_rand       = 1'b1;
        rand_hi        = 31;
        bus.out_ready  = 1'b1;
        exp_pc         = 32'hFFFF_FFFC;
        n_pop          = 0;
        mon_en         = 1'b1;
        for (int i = 0; i < 60000 && n_pop < 1000; i++) tick();
        mon_en = 1'b0;
        check32("stream_count", 32'(n_pop >= 1000), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
